// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use interlock, branch flush and data-memory wait/timeout.
// Optional stall-cycle counter is built only when STALL_CNT_EN is defined.
module pipe_hazard_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        ex_wreg,
  input  logic        ex_m2reg,
  input  logic [4:0]  ex_rdrt,
  input  logic        branch_taken,
  input  logic        mem_req,
  input  logic        mem_ack,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        idex_en,
  output logic        idex_flush,
  output logic        exmem_en,
  output logic        memwb_en,
  output logic        mem_timeout,
  output logic [31:0] stall_cycles,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  // The wait that brings the counter up to TIMEOUT moves straight to ERR.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t     state, state_nxt;
  logic [7:0] wait_cnt, wait_cnt_nxt;
  logic       lu_hazard;
  logic       mem_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      RUN: begin
        if (mem_req && !mem_ack) begin
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = '0;
        end
      end
      MEM_WAIT: begin
        if (mem_ack) begin
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
        end else if (wait_cnt == TIMEOUT_LAST) begin
          state_nxt    = ERR;
          wait_cnt_nxt = '0;
        end else begin
          wait_cnt_nxt = wait_cnt + 8'd1;
        end
      end
      ERR:     state_nxt = ERR;
      default: state_nxt = RUN;
    endcase
  end

  assign lu_hazard = ex_wreg && ex_m2reg && (ex_rdrt != 5'd0) &&
                     ((id_uses_rs && (id_rs == ex_rdrt)) ||
                      (id_uses_rt && (id_rt == ex_rdrt)));

  assign mem_stall = ((state == RUN) && mem_req && !mem_ack) ||
                     ((state == MEM_WAIT) && !mem_ack) ||
                     (state == ERR);

  // A load-use stall holds ID, so a coincident branch re-resolves next cycle
  // and must not flush the held instruction.
  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    idex_en    = 1'b1;
    exmem_en   = 1'b1;
    memwb_en   = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (rst) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_en    = 1'b0;
      exmem_en   = 1'b0;
      memwb_en   = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (mem_stall) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
    end else if (lu_hazard) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end else if (branch_taken) begin
      ifid_flush = 1'b1;
    end
  end

  assign mem_timeout = (state == ERR) && !rst;
  assign state_dbg   = state;

`ifdef STALL_CNT_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (!pc_en && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign stall_cycles = stall_cnt;
`else
  assign stall_cycles = '0;
`endif

endmodule
